// File: rtl/stm32_iq_streamer.sv
// Buffers multi-channel RX IQ sample sets and streams them byte-serially
// to the STM32 over the 8-bit DATA_BUS under DATA_SYNC command framing.
module stm32_iq_streamer #(
    parameter int         RX_CHANNELS  = 2,
    parameter int         SAMPLE_WIDTH = 24,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] CMD_RX_IQ    = 8'd4,
    parameter logic [7:0] CMD_STATUS   = 8'd2
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n,
    input  logic                                  DATA_SYNC,
    input  logic [7:0]                            DATA_BUS_IN,
    output logic [7:0]                            DATA_BUS_OUT,
    output logic                                  DATA_BUS_OE,
    input  logic [RX_CHANNELS-1:0]                rx_enable,
    input  logic                                  iq_in_valid,
    input  logic [RX_CHANNELS*SAMPLE_WIDTH-1:0]   iq_in_i,
    input  logic [RX_CHANNELS*SAMPLE_WIDTH-1:0]   iq_in_q,
    output logic                                  iq_overrun,
    output logic                                  iq_underrun,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level
);

    localparam int BYTES = SAMPLE_WIDTH / 8;
    localparam int CH_W  = RX_CHANNELS * SAMPLE_WIDTH;
    localparam int SET_W = 2 * CH_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CW    = (RX_CHANNELS > 1) ? $clog2(RX_CHANNELS) : 1;
    localparam int BW    = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, STREAM, ST0, ST1} state_t;

    state_t                 state_q, state_d;
    logic                   oe_q, oe_d;
    logic [7:0]             dout_q, dout_d;
    logic                   ovr_q, ovr_d;
    logic                   udr_q, udr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [SET_W-1:0]       held_q, held_d;
    logic [RX_CHANNELS-1:0] mask_q, mask_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic                   half_q, half_d;
    logic [BW-1:0]          bsel_q, bsel_d;
    logic                   start_q, start_d;

    logic [SET_W-1:0]       mem_q [FIFO_DEPTH];

    logic                   full, empty, pop, wr_en;
    logic                   ovr_evt, udr_evt;
    logic                   nxt_found;
    logic [CW-1:0]          nxt_ch, fch;
    logic [RX_CHANNELS-1:0] fmask;
    logic [SET_W-1:0]       src;

    // Set packing is {Q of all channels, I of all channels}; half=1 selects I.
    function automatic logic [7:0] pick_byte(
        input logic [SET_W-1:0] set,
        input logic [CW-1:0]    ch,
        input logic             half,
        input logic [BW-1:0]    bsel
    );
        int               base;
        logic [SET_W-1:0] sh;
        base = (half ? 0 : CH_W) + int'(ch) * SAMPLE_WIDTH
             + (BYTES - 1 - int'(bsel)) * 8;
        sh = set >> base;
        return sh[7:0];
    endfunction

    function automatic logic [CW-1:0] first_ch(
        input logic [RX_CHANNELS-1:0] m
    );
        logic [CW-1:0] f;
        f = '0;
        for (int c = RX_CHANNELS - 1; c >= 0; c--) begin
            if (m[c]) f = CW'(c);
        end
        return f;
    endfunction

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = ch_q;
        for (int c = RX_CHANNELS - 1; c >= 0; c--) begin
            if (mask_q[c] && c > int'(ch_q)) begin
                nxt_found = 1'b1;
                nxt_ch    = CW'(c);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        oe_d     = oe_q;
        dout_d   = dout_q;
        ovr_d    = ovr_q;
        udr_d    = udr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        held_d   = held_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        half_d   = half_q;
        bsel_d   = bsel_q;
        start_d  = start_q;
        pop      = 1'b0;
        udr_evt  = 1'b0;
        fmask    = '0;
        fch      = '0;
        src      = held_q;

        if (DATA_SYNC) begin
            if (DATA_BUS_IN == CMD_RX_IQ) begin
                oe_d    = 1'b1;
                state_d = STREAM;
                start_d = 1'b1;
            end else if (DATA_BUS_IN == CMD_STATUS) begin
                oe_d    = 1'b1;
                state_d = ST0;
            end else begin
                oe_d    = 1'b0;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                STREAM: begin
                    if (start_q) begin
                        fmask  = (rx_enable == '0) ?
                                 RX_CHANNELS'(1) : rx_enable;
                        fch    = first_ch(fmask);
                        mask_d = fmask;
                        if (!empty) begin
                            pop = 1'b1;
                            src = mem_q[rd_ptr_q];
                        end else begin
                            udr_evt = 1'b1;
                        end
                        held_d  = src;
                        dout_d  = pick_byte(src, fch, 1'b0, '0);
                        ch_d    = fch;
                        half_d  = 1'b0;
                        bsel_d  = BW'(1);
                        start_d = 1'b0;
                    end else begin
                        dout_d = pick_byte(held_q, ch_q, half_q, bsel_q);
                        if (bsel_q != BW'(BYTES - 1)) begin
                            bsel_d = bsel_q + BW'(1);
                        end else begin
                            bsel_d = '0;
                            if (!half_q) begin
                                half_d = 1'b1;
                            end else begin
                                half_d = 1'b0;
                                if (nxt_found) ch_d = nxt_ch;
                                else start_d = 1'b1;
                            end
                        end
                    end
                end
                ST0: begin
                    dout_d  = {6'b0, udr_q, ovr_q};
                    ovr_d   = 1'b0;
                    udr_d   = 1'b0;
                    state_d = ST1;
                end
                ST1: begin
                    dout_d  = 8'(level_q);
                    state_d = IDLE;
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end

        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        wr_en   = iq_in_valid && (!full || pop);
        ovr_evt = iq_in_valid && !wr_en;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        level_d = level_q + LW'(wr_en) - LW'(pop);
        if (ovr_evt) ovr_d = 1'b1;
        if (udr_evt) udr_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            oe_q     <= 1'b0;
            dout_q   <= '0;
            ovr_q    <= 1'b0;
            udr_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            held_q   <= '0;
            mask_q   <= '0;
            ch_q     <= '0;
            half_q   <= 1'b0;
            bsel_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            ovr_q    <= ovr_d;
            udr_q    <= udr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            held_q   <= held_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            half_q   <= half_d;
            bsel_q   <= bsel_d;
            start_q  <= start_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[wr_ptr_q] <= {iq_in_q, iq_in_i};
    end

    assign DATA_BUS_OUT = dout_q;
    assign DATA_BUS_OE  = oe_q;
    assign iq_overrun   = ovr_q;
    assign iq_underrun  = udr_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_stm32_iq_streamer.sv
// Bench for stm32_iq_streamer: directed scenarios plus random traffic,
// checked every edge against a frame-level queue model.
module tb_stm32_iq_streamer;

    localparam int RX    = 2;
    localparam int SW    = 24;
    localparam int DEPTH = 4;
    localparam int NB    = SW / 8;

    typedef struct packed {
        logic [RX*SW-1:0] q;
        logic [RX*SW-1:0] i;
    } set_t;

    logic              clk_in = 1'b0;
    logic              reset_n;
    logic              DATA_SYNC;
    logic [7:0]        DATA_BUS_IN;
    logic [7:0]        DATA_BUS_OUT;
    logic              DATA_BUS_OE;
    logic [RX-1:0]     rx_enable;
    logic              iq_in_valid;
    logic [RX*SW-1:0]  iq_in_i;
    logic [RX*SW-1:0]  iq_in_q;
    logic              iq_overrun;
    logic              iq_underrun;
    logic [2:0]        fifo_level;

    stm32_iq_streamer #(
        .RX_CHANNELS(RX), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .DATA_SYNC(DATA_SYNC), .DATA_BUS_IN(DATA_BUS_IN),
        .DATA_BUS_OUT(DATA_BUS_OUT), .DATA_BUS_OE(DATA_BUS_OE),
        .rx_enable(rx_enable), .iq_in_valid(iq_in_valid),
        .iq_in_i(iq_in_i), .iq_in_q(iq_in_q),
        .iq_overrun(iq_overrun), .iq_underrun(iq_underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: FIFO as a queue, whole frame expanded into a byte queue at start.
    set_t       mq[$];
    set_t       mheld;
    logic [7:0] mframe[$];
    int         mstate;
    logic       moe, movr, mudr;
    logic [7:0] mout;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic set_t rand_set();
        set_t s;
        s.q = (RX*SW)'({$urandom(), $urandom()});
        s.i = (RX*SW)'({$urandom(), $urandom()});
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        mframe.delete();
        mheld  = '0;
        mstate = 0;
        moe    = 1'b0;
        movr   = 1'b0;
        mudr   = 1'b0;
        mout   = 8'h00;
    endtask

    task automatic model_edge(input logic sync, input logic [7:0] cmd,
                              input logic vld, input set_t s,
                              input logic [RX-1:0] mask);
        int         lvl;
        bit         popped;
        bit         ue;
        bit         oe_ev;
        logic [RX-1:0]    m;
        logic [RX*SW-1:0] t;
        lvl    = mq.size();
        popped = 0;
        ue     = 0;
        oe_ev  = 0;
        if (sync) begin
            mframe.delete();
            if (cmd == 8'h04) begin
                moe = 1'b1; mstate = 1;
            end else if (cmd == 8'h02) begin
                moe = 1'b1; mstate = 2;
            end else begin
                moe = 1'b0; mstate = 0;
            end
        end else begin
            case (mstate)
                1: begin
                    if (mframe.size() == 0) begin
                        m = (mask == 0) ? RX'(1) : mask;
                        if (lvl > 0) begin
                            mheld  = mq.pop_front();
                            popped = 1;
                        end else begin
                            ue = 1;
                        end
                        for (int c = 0; c < RX; c++) begin
                            if (m[c]) begin
                                for (int b = 0; b < NB; b++) begin
                                    t = mheld.q >> (c*SW + 8*(NB-1-b));
                                    mframe.push_back(t[7:0]);
                                end
                                for (int b = 0; b < NB; b++) begin
                                    t = mheld.i >> (c*SW + 8*(NB-1-b));
                                    mframe.push_back(t[7:0]);
                                end
                            end
                        end
                    end
                    mout = mframe.pop_front();
                end
                2: begin
                    mout   = {6'b0, mudr, movr};
                    movr   = 1'b0;
                    mudr   = 1'b0;
                    mstate = 3;
                end
                3: begin
                    mout   = 8'(lvl);
                    mstate = 0;
                end
                default: moe = 1'b0;
            endcase
        end
        if (vld) begin
            if (lvl < DEPTH || popped) mq.push_back(s);
            else oe_ev = 1;
        end
        if (oe_ev) movr = 1'b1;
        if (ue)    mudr = 1'b1;
    endtask

    task automatic step(input logic sync, input logic [7:0] cmd,
                        input logic vld, input set_t s,
                        input logic [RX-1:0] mask);
        DATA_SYNC   = sync;
        DATA_BUS_IN = cmd;
        iq_in_valid = vld;
        iq_in_q     = s.q;
        iq_in_i     = s.i;
        rx_enable   = mask;
        model_edge(sync, cmd, vld, s, mask);
        @(posedge clk_in);
        #1;
        chk("oe",    DATA_BUS_OE,  moe);
        chk("dout",  DATA_BUS_OUT, mout);
        chk("level", fifo_level,   mq.size());
        chk("ovr",   iq_overrun,   movr);
        chk("udr",   iq_underrun,  mudr);
    endtask

    task automatic idle(input int n, input logic [RX-1:0] mask);
        for (int k = 0; k < n; k++) step(0, 8'h00, 0, '0, mask);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oe"},   DATA_BUS_OE,  0);
        chk({tag, "_dout"}, DATA_BUS_OUT, 0);
        chk({tag, "_ovr"},  iq_overrun,   0);
        chk({tag, "_udr"},  iq_underrun,  0);
        chk({tag, "_lvl"},  fifo_level,   0);
    endtask

    initial begin
        logic [7:0] exp1 [6];
        set_t       s;
        logic [RX-1:0] rmask;
        exp1 = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};

        reset_n     = 1'b0;
        DATA_SYNC   = 1'b0;
        DATA_BUS_IN = 8'h00;
        iq_in_valid = 1'b0;
        iq_in_i     = '0;
        iq_in_q     = '0;
        rx_enable   = 2'b01;
        model_reset();
        #2;
        chk_reset_outputs("rst");
        @(negedge clk_in);
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;

        // Single channel frame, then an underrun repeat of the same bytes.
        s = rand_set();
        s.q[SW-1:0] = 24'h123456;
        s.i[SW-1:0] = 24'hABCDEF;
        step(0, 8'h00, 1, s, 2'b01);
        step(1, 8'h04, 0, '0, 2'b01);
        chk("t1_oe", DATA_BUS_OE, 1);
        for (int k = 0; k < 12; k++) begin
            step(0, 8'h00, 0, '0, 2'b01);
            chk("t1_byte", DATA_BUS_OUT, exp1[k % 6]);
        end
        chk("t1_udr", iq_underrun, 1);
        step(1, 8'h09, 0, '0, 2'b01);

        // Two channels, two sets; then a status read to clear the flags.
        step(0, 8'h00, 1, rand_set(), 2'b11);
        step(0, 8'h00, 1, rand_set(), 2'b11);
        step(1, 8'h04, 0, '0, 2'b11);
        idle(24, 2'b11);
        chk("t2_lvl", fifo_level, 0);
        step(1, 8'h02, 0, '0, 2'b11);
        idle(3, 2'b11);

        // Overrun with no reads, status read, then drain all four sets.
        for (int k = 0; k < 6; k++) step(0, 8'h00, 1, rand_set(), 2'b11);
        chk("t3_lvl", fifo_level, 4);
        chk("t3_ovr", iq_overrun, 1);
        step(1, 8'h02, 0, '0, 2'b11);
        step(0, 8'h00, 0, '0, 2'b11);
        chk("t3_st0", DATA_BUS_OUT, 8'h01);
        step(0, 8'h00, 0, '0, 2'b11);
        chk("t3_st1", DATA_BUS_OUT, 8'h04);
        chk("t3_ovr_clr", iq_overrun, 0);
        step(0, 8'h00, 0, '0, 2'b11);
        chk("t3_oe_drop", DATA_BUS_OE, 0);
        step(1, 8'h04, 0, '0, 2'b11);
        idle(48, 2'b11);

        // Abort mid-frame, restart with next entry, then an invalid command.
        step(0, 8'h00, 1, rand_set(), 2'b11);
        step(0, 8'h00, 1, rand_set(), 2'b11);
        step(1, 8'h04, 0, '0, 2'b11);
        idle(4, 2'b11);
        step(1, 8'h04, 0, '0, 2'b11);
        idle(12, 2'b11);
        step(1, 8'h09, 0, '0, 2'b11);
        chk("t4_oe", DATA_BUS_OE, 0);
        idle(2, 2'b11);

        // Random traffic.
        rmask = 2'b11;
        for (int k = 0; k < 1500; k++) begin
            logic       sy;
            logic [7:0] cmd;
            int         r;
            if ($urandom_range(0, 49) == 0) rmask = RX'($urandom_range(0, 3));
            sy  = ($urandom_range(0, 39) == 0);
            r   = $urandom_range(0, 4);
            cmd = (r < 2) ? 8'h04 : (r == 2) ? 8'h02 :
                  (r == 3) ? 8'h09 : 8'($urandom());
            step(sy, cmd, ($urandom_range(0, 7) == 0), rand_set(), rmask);
        end

        // Asynchronous reset while streaming with three entries queued.
        step(1, 8'h09, 0, '0, 2'b11);
        step(1, 8'h02, 0, '0, 2'b11);
        idle(3, 2'b11);
        while (mq.size() > 0) begin
            step(1, 8'h04, 0, '0, 2'b11);
            step(0, 8'h00, 0, '0, 2'b11);
        end
        step(1, 8'h09, 0, '0, 2'b11);
        for (int k = 0; k < 4; k++) step(0, 8'h00, 1, rand_set(), 2'b11);
        step(1, 8'h04, 0, '0, 2'b11);
        step(0, 8'h00, 0, '0, 2'b11);
        chk("t6_lvl", fifo_level, 3);
        chk("t6_oe", DATA_BUS_OE, 1);
        DATA_SYNC   = 1'b0;
        iq_in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("arst");
        @(negedge clk_in);
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        chk_reset_outputs("post");
        idle(2, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
